// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop sequencer.
//   riscv_hwloop_state_e : sequencer state (idle / redirect pending)
//   HWLP_DEFAULT_N_REGS  : default number of loop register sets
//   HWLP_WIDTH           : address and counter width
package riscv_hwloop_pkg;

  localparam int unsigned HWLP_DEFAULT_N_REGS = 2;
  localparam int unsigned HWLP_WIDTH          = 32;

  typedef enum logic [0:0] {
    HWLP_IDLE    = 1'b0,
    HWLP_PENDING = 1'b1
  } riscv_hwloop_state_e;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-address compare with lowest-index priority selection.
//   enable_i      : matching allowed this cycle (idle, issued, not flushed)
//   pc_i          : address of the issuing instruction
//   end_addr_i    : loop end addresses
//   counter_i     : loop counters; zero marks a loop as inactive
//   match_valid_o : some loop matched
//   winner_o      : index of the lowest matching loop
//   winner_last_o : winner is on its final iteration (counter == 1)
//   dec_cnt_o     : one-hot decrement for the winner, zero otherwise
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = HWLP_DEFAULT_N_REGS,
  parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                                enable_i,
  input  logic [HWLP_WIDTH-1:0]               pc_i,
  input  logic [N_REGS-1:0][HWLP_WIDTH-1:0]   end_addr_i,
  input  logic [N_REGS-1:0][HWLP_WIDTH-1:0]   counter_i,
  output logic                                match_valid_o,
  output logic [N_REG_BITS-1:0]               winner_o,
  output logic                                winner_last_o,
  output logic [N_REGS-1:0]                   dec_cnt_o
);

  logic [N_REGS-1:0] hit;

  always_comb begin
    for (int k = 0; k < N_REGS; k++) begin
      hit[k] = enable_i && (pc_i == end_addr_i[k]) && (counter_i[k] != '0);
    end
  end

  // Only the first (innermost) hit is acted on, so at most one decrement per cycle.
  always_comb begin
    match_valid_o = 1'b0;
    winner_o      = '0;
    winner_last_o = 1'b0;
    dec_cnt_o     = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (hit[k] && !match_valid_o) begin
        match_valid_o = 1'b1;
        winner_o      = N_REG_BITS'(k);
        winner_last_o = (counter_i[k] == HWLP_WIDTH'(1));
        dec_cnt_o[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// Hardware-loop sequencer: detects loop-end hits on the issuing PC, strobes the
// register-file decrement and holds a redirect request to fetch until accepted.
//   clk, rst          : clock, asynchronous active-high reset
//   hwlp_start_addr_i : loop start addresses
//   hwlp_end_addr_i   : loop end addresses
//   hwlp_counter_i    : loop counters
//   pc_i, pc_valid_i  : issuing instruction address and its issue strobe
//   jump_ack_i        : fetch accepts the redirect this cycle
//   flush_i           : kills a pending redirect / suppresses this cycle's match
//   hwlp_dec_cnt_o    : one-hot decrement strobe (combinational)
//   jump_req_o        : redirect request (registered)
//   jump_target_o     : redirect address (registered)
//   busy_o            : redirect pending
//   hwlp_jump_cnt_o   : number of acknowledged loop-back jumps (wraps)
module riscv_hwloop_sequencer
  import riscv_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = HWLP_DEFAULT_N_REGS,
  parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REGS-1:0][HWLP_WIDTH-1:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][HWLP_WIDTH-1:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][HWLP_WIDTH-1:0] hwlp_counter_i,
  input  logic [HWLP_WIDTH-1:0]             pc_i,
  input  logic                              pc_valid_i,
  input  logic                              jump_ack_i,
  input  logic                              flush_i,
  output logic [N_REGS-1:0]                 hwlp_dec_cnt_o,
  output logic                              jump_req_o,
  output logic [HWLP_WIDTH-1:0]             jump_target_o,
  output logic                              busy_o,
  output logic [HWLP_WIDTH-1:0]             hwlp_jump_cnt_o
);

  riscv_hwloop_state_e   state_q;
  logic [HWLP_WIDTH-1:0] jump_target_q;
  logic [HWLP_WIDTH-1:0] jump_cnt_q;

  logic                  match_en;
  logic                  match_valid;
  logic [N_REG_BITS-1:0] winner;
  logic                  winner_last;
  logic [N_REGS-1:0]     dec_cnt;

  // Matching is suspended while a redirect is outstanding and on flush.
  assign match_en = (state_q == HWLP_IDLE) && pc_valid_i && !flush_i;

  riscv_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .enable_i      (match_en),
    .pc_i          (pc_i),
    .end_addr_i    (hwlp_end_addr_i),
    .counter_i     (hwlp_counter_i),
    .match_valid_o (match_valid),
    .winner_o      (winner),
    .winner_last_o (winner_last),
    .dec_cnt_o     (dec_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HWLP_IDLE;
      jump_target_q <= '0;
      jump_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        HWLP_IDLE: begin
          // Final iteration only decrements; otherwise loop back to start.
          if (match_valid && !winner_last) begin
            jump_target_q <= hwlp_start_addr_i[winner];
            state_q       <= HWLP_PENDING;
          end
        end
        HWLP_PENDING: begin
          // Flush takes precedence over a simultaneous acknowledge.
          if (flush_i) begin
            state_q <= HWLP_IDLE;
          end else if (jump_ack_i) begin
            state_q    <= HWLP_IDLE;
            jump_cnt_q <= jump_cnt_q + HWLP_WIDTH'(1);
          end
        end
        default: state_q <= HWLP_IDLE;
      endcase
    end
  end

  assign hwlp_dec_cnt_o  = rst ? '0 : dec_cnt;
  assign jump_req_o      = (state_q == HWLP_PENDING);
  assign busy_o          = (state_q == HWLP_PENDING);
  assign jump_target_o   = jump_target_q;
  assign hwlp_jump_cnt_o = jump_cnt_q;

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// Directed bench for riscv_hwloop_sequencer with an expected-output scoreboard.
module tb_riscv_hwloop_sequencer;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][31:0] start_addr;
  logic [1:0][31:0] end_addr;
  logic [1:0][31:0] counter;
  logic [31:0]      pc;
  logic             pc_valid;
  logic             jump_ack;
  logic             flush;
  logic [1:0]       dec_cnt;
  logic             jump_req;
  logic [31:0]      jump_target;
  logic             busy;
  logic [31:0]      jump_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [1:0]  dec;
    logic        req;
    logic [31:0] tgt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_hwloop_sequencer #(
    .N_REGS (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_start_addr_i (start_addr),
    .hwlp_end_addr_i   (end_addr),
    .hwlp_counter_i    (counter),
    .pc_i              (pc),
    .pc_valid_i        (pc_valid),
    .jump_ack_i        (jump_ack),
    .flush_i           (flush),
    .hwlp_dec_cnt_o    (dec_cnt),
    .jump_req_o        (jump_req),
    .jump_target_o     (jump_target),
    .busy_o            (busy),
    .hwlp_jump_cnt_o   (jump_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] dec, input logic req,
                            input logic [31:0] tgt, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag;
    e.dec = dec;
    e.req = req;
    e.tgt = tgt;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare against the current outputs.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".dec"}, 32'(dec_cnt), 32'(e.dec));
      chk({e.tag, ".req"}, 32'(jump_req), 32'(e.req));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.req));
      chk({e.tag, ".tgt"}, jump_target, e.tgt);
      chk({e.tag, ".cnt"}, jump_cnt, e.cnt);
    end
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+4.
  task automatic cycle();
    #3;
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic a, input logic f);
    pc_valid = v;
    pc       = p;
    jump_ack = a;
    flush    = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    start_addr = '0;
    end_addr   = '0;
    counter    = '0;
    // Loop 0 configured and hitting while in reset: no decrement may escape.
    start_addr[0] = 32'h100;
    end_addr[0]   = 32'h11C;
    counter[0]    = 32'd3;
    drive(1'b1, 32'h11C, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("reset", 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();

    rst = 1'b0;
    // Taken iteration.
    expect_out("take.match", 2'b01, 1'b0, 32'h0, 32'h0);
    cycle();
    expect_out("take.pend", 2'b00, 1'b1, 32'h100, 32'h0);  // pc still at end: ignored
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("take.ack", 2'b00, 1'b1, 32'h100, 32'h0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("take.done", 2'b00, 1'b0, 32'h100, 32'h1);
    cycle();

    // Last iteration: decrement only.
    counter[0] = 32'd1;
    drive(1'b1, 32'h11C, 1'b0, 1'b0);
    expect_out("last.match", 2'b01, 1'b0, 32'h100, 32'h1);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("last.after", 2'b00, 1'b0, 32'h100, 32'h1);
    cycle();

    // Shared end address: loop 0 wins.
    start_addr[0] = 32'h300;
    end_addr[0]   = 32'h200;
    counter[0]    = 32'd2;
    start_addr[1] = 32'h400;
    end_addr[1]   = 32'h200;
    counter[1]    = 32'd5;
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    expect_out("prio0.match", 2'b01, 1'b0, 32'h100, 32'h1);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("prio0.pend", 2'b00, 1'b1, 32'h300, 32'h1);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("prio0.done", 2'b00, 1'b0, 32'h300, 32'h2);
    cycle();

    // Inactive loop 0: loop 1 takes over.
    counter[0] = 32'd0;
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    expect_out("prio1.match", 2'b10, 1'b0, 32'h300, 32'h2);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("prio1.pend", 2'b00, 1'b1, 32'h400, 32'h2);
    cycle();
    // Back-to-back: first idle cycle matches again.
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    expect_out("b2b.match", 2'b10, 1'b0, 32'h400, 32'h3);
    cycle();

    // Flush and ack together while pending.
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    expect_out("flush.pend", 2'b00, 1'b1, 32'h400, 32'h3);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("flush.idle", 2'b00, 1'b0, 32'h400, 32'h3);
    cycle();

    // Flush in idle suppresses the match.
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    expect_out("iflush.match", 2'b00, 1'b0, 32'h400, 32'h3);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("iflush.after", 2'b00, 1'b0, 32'h400, 32'h3);
    cycle();

    // Stall: request held while pc keeps hitting the end address.
    start_addr[1] = 32'h480;
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    expect_out("stall.match", 2'b10, 1'b0, 32'h400, 32'h3);
    cycle();
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("stall.hold%0d", i), 2'b00, 1'b1, 32'h480, 32'h3);
      cycle();
    end

    // Asynchronous reset mid-cycle while pending.
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst", 2'b00, 1'b0, 32'h0, 32'h0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("post.match", 2'b10, 1'b0, 32'h0, 32'h0);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("post.pend", 2'b00, 1'b1, 32'h480, 32'h0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("post.done", 2'b00, 1'b0, 32'h480, 32'h1);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
